// File: rtl/mem_arb_3p.sv
// Arbitrates two camera writers and one display reader onto a split memory command port.
// Optional build macro ARB_RD_PRIORITY_EN: an eligible reader always wins, writers round-robin.
module mem_arb_3p #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_RD_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr0_req,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  output logic              wr0_gnt,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data_out,
  output logic              rd_valid_out,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_rdy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_rd_data_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              err
);

  localparam int unsigned CNT_W = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  localparam logic [1:0] SRC_WR0 = 2'd0;
  localparam logic [1:0] SRC_WR1 = 2'd1;
  localparam logic [1:0] SRC_RD  = 2'd2;

  logic [0:0]        state, state_nxt;
  logic [1:0]        rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [2:0]        elig;
  logic              win_vld;
  logic [1:0]        win;
  logic [1:0]        cand;
`ifndef ARB_RD_PRIORITY_EN
  logic [2:0]        slot;
`endif

  logic              wr0_gnt_nxt, wr1_gnt_nxt, rd_gnt_nxt;
  logic              wr_en_nxt, rd_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;

  assign elig = {rd_req & mem_rd_rdy & (rd_cnt < CNT_W'(MAX_RD_OUT)),
                 wr1_req & mem_wr_rdy,
                 wr0_req & mem_wr_rdy};

  // Winner pick: first eligible source scanning from the round-robin pointer
  always_comb begin
    win_vld = 1'b0;
    win     = SRC_WR0;
    cand    = SRC_WR0;
`ifdef ARB_RD_PRIORITY_EN
    if (elig[SRC_RD]) begin
      win_vld = 1'b1;
      win     = SRC_RD;
    end
    for (int unsigned k = 0; k < 2; k++) begin
      cand = {1'b0, rr_ptr[0] ^ k[0]};
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
`else
    slot = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      slot = 3'(rr_ptr) + 3'(k);
      if (slot >= 3'd3) slot = slot - 3'd3;
      cand = slot[1:0];
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
`endif
  end

  // Next state and next registered outputs; addresses/data hold unless loaded
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    wr0_gnt_nxt = 1'b0;
    wr1_gnt_nxt = 1'b0;
    rd_gnt_nxt  = 1'b0;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    wr_addr_nxt = mem_wr_addr;
    wr_data_nxt = mem_wr_data;
    rd_addr_nxt = mem_rd_addr;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = ISSUE;
`ifdef ARB_RD_PRIORITY_EN
          if (win != SRC_RD) rr_ptr_nxt = {1'b0, ~win[0]};
`else
          rr_ptr_nxt = (win == SRC_RD) ? SRC_WR0 : win + 2'd1;
`endif
          case (win)
            SRC_WR0: begin
              wr0_gnt_nxt = 1'b1;
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = wr0_addr;
              wr_data_nxt = wr0_data;
            end
            SRC_WR1: begin
              wr1_gnt_nxt = 1'b1;
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = wr1_addr;
              wr_data_nxt = wr1_data;
            end
            default: begin
              rd_gnt_nxt  = 1'b1;
              rd_en_nxt   = 1'b1;
              rd_addr_nxt = rd_addr;
            end
          endcase
        end
      end
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= SRC_WR0;
      wr0_gnt     <= 1'b0;
      wr1_gnt     <= 1'b0;
      rd_gnt      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_addr <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      wr0_gnt     <= wr0_gnt_nxt;
      wr1_gnt     <= wr1_gnt_nxt;
      rd_gnt      <= rd_gnt_nxt;
      mem_wr_en   <= wr_en_nxt;
      mem_rd_en   <= rd_en_nxt;
      mem_wr_addr <= wr_addr_nxt;
      mem_wr_data <= wr_data_nxt;
      mem_rd_addr <= rd_addr_nxt;
    end
  end

  // Outstanding reads; a return with nothing outstanding is a sticky protocol error
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      err    <= 1'b0;
    end else if (mem_rd_en && !mem_rd_data_valid) begin
      rd_cnt <= rd_cnt + CNT_W'(1);
    end else if (!mem_rd_en && mem_rd_data_valid) begin
      if (rd_cnt == '0) err    <= 1'b1;
      else              rd_cnt <= rd_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_out <= 1'b0;
      rd_data_out  <= '0;
    end else begin
      rd_valid_out <= mem_rd_data_valid;
      rd_data_out  <= mem_rd_data;
    end
  end

endmodule
